// File: rtl/neuron_seq.sv
// neuron_seq: sequential multiply-accumulate neuron with ready/valid handshakes.
//
// The block accepts one input vector per transaction. It adds the products
// sext(weight) * zext(input) to a sign-extended bias, handling Lanes channels
// per cycle. When every channel group has been summed, it presents the result
// on a registered valid/data pair and holds it until downstream accepts it.
//
// Optional feature (compile-time macro):
//   NEURON_SEQ_RELU_EN - when defined, a negative final sum is replaced by 0
//                        on its way to data_o. When undefined, the raw signed
//                        sum is driven.
//
// Arithmetic is carried at WidthOut bits and wraps modulo 2^WidthOut.

module neuron_seq #(
    parameter int unsigned                      WidthIn     = 1,
    parameter int unsigned                      WidthOut    = 32,
    parameter int unsigned                      WeightWidth = 2,
    parameter int unsigned                      BiasWidth   = 8,
    parameter int unsigned                      InChannels  = 4,
    parameter int unsigned                      Lanes       = 1,
    parameter logic [InChannels*WeightWidth-1:0] Weights    = '0,
    parameter logic signed [BiasWidth-1:0]      Bias        = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [InChannels-1:0][WidthIn-1:0]   data_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic signed [WidthOut-1:0]           data_o
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    // Number of channel groups, one group consumed per ACCUM cycle.
    localparam int unsigned NumGroups = InChannels / Lanes;
    // The group counter needs at least one bit even when there is one group.
    localparam int unsigned GroupW    = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam logic [GroupW-1:0] LastGroup = GroupW'(NumGroups - 1);

    // ------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------
    if (InChannels < 1) begin : g_bad_channels
        $error("neuron_seq: InChannels must be at least 1");
    end
    if ((Lanes < 1) || ((InChannels % Lanes) != 0)) begin : g_bad_lanes
        $error("neuron_seq: InChannels must be a multiple of Lanes");
    end

    // ------------------------------------------------------------------
    // Types and state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                           state;
    logic [InChannels*WidthIn-1:0]    data_r;    // captured input vector
    logic [GroupW-1:0]                grp;       // group being accumulated
    logic signed [WidthOut-1:0]       acc;       // running sum
    logic signed [WidthOut-1:0]       grp_sum;   // sum of this cycle's products
    logic signed [WidthOut-1:0]       acc_next;  // acc after this cycle's group

    // Scratch values for the lane loop
    int unsigned                      lane_ch;
    logic signed [WeightWidth-1:0]    lane_w;
    logic [WidthIn-1:0]               lane_x;

    // The bias is sign-extended (or truncated) once, at WidthOut bits.
    localparam logic signed [WidthOut-1:0] BiasExt = WidthOut'(Bias);

    // ------------------------------------------------------------------
    // Final-value shaping on entry to DONE
    // ------------------------------------------------------------------
    function automatic logic signed [WidthOut-1:0] shape_result(
        input logic signed [WidthOut-1:0] value
    );
`ifdef NEURON_SEQ_RELU_EN
        // Negative sums are clamped to zero.
        return value[WidthOut-1] ? '0 : value;
`else
        // The raw signed sum passes through, negative values included.
        return value;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Datapath: products of the current channel group, summed at WidthOut
    // ------------------------------------------------------------------
    // Sum the current group's Lanes products and form the next accumulator value.
    always_comb begin
        // NOTE: every variable written here gets a default first; this keeps the block free of inferred latches.
        grp_sum = '0;
        lane_ch = '0;
        lane_w  = '0;
        lane_x  = '0;
        for (int unsigned l = 0; l < Lanes; l++) begin
            lane_ch = 32'(grp) * Lanes + l;
            lane_w  = Weights[lane_ch*WeightWidth +: WeightWidth];
            lane_x  = data_r[lane_ch*WidthIn +: WidthIn];
            // Both operands are extended to WidthOut first. The weight is
            // sign-extended and the input zero-extended, so the wrapped
            // product has the intended value in WidthOut bits.
            grp_sum = grp_sum + (WidthOut'(lane_w) * WidthOut'(lane_x));
        end
        acc_next = acc + grp_sum;
    end

    // ------------------------------------------------------------------
    // Handshake decode: ready depends on the state register only
    // ------------------------------------------------------------------
    assign ready_o = (state == IDLE);

    // ------------------------------------------------------------------
    // Control FSM with registered result outputs
    // ------------------------------------------------------------------
    // Sequence IDLE -> ACCUM (one group per cycle) -> DONE, and drive valid_o and data_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the captured input vector is a small register, not a memory,
            //       so it is reset along with the rest; any reset drops the transaction.
            state   <= IDLE;
            data_r  <= '0;
            grp     <= '0;
            acc     <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment, so every
            //       right-hand side below sees values from before this edge.
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        data_r <= data_i;
                        acc    <= BiasExt;
                        grp    <= '0;
                        state  <= ACCUM;
                    end
                end

                ACCUM: begin
                    acc <= acc_next;
                    if (grp == LastGroup) begin
                        // The last group: register the result on the edge we enter DONE.
                        data_o  <= shape_result(acc_next);
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end

                DONE: begin
                    // data_o stays as it is here and afterwards. Only valid_o qualifies it.
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule : neuron_seq

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: self-checking bench for neuron_seq.
//
// Five instances run side by side on shared stimulus:
//   0: Lanes=1, Bias=+3, weights {+1,-1,-2,+1}
//   1: Lanes=2, Bias=+3, weights {+1,-1,-2,+1}
//   2: Lanes=4, Bias=+3, weights {+1,-1,-2,+1}
//   3: Lanes=1, Bias=-4, weights {+1,-1,-2,+1}
//   4: Lanes=1, Bias=+7, weights all +1, WidthOut=4 (wrap-around)
// A transaction-level model predicts, for every cycle, ready_o, valid_o and
// data_o of each instance. Directed sequences add hand-computed literals.
// The bench honours NEURON_SEQ_RELU_EN for its expectations.

module tb_neuron_seq;

    localparam int NDUT = 5;

    // Configuration handed to the DUTs (packed encodings)
    localparam int          LANES [NDUT] = '{1, 2, 4, 1, 1};
    localparam int          WOUT  [NDUT] = '{32, 32, 32, 32, 4};
    localparam logic [7:0]  WPACK [NDUT] = '{8'b01_10_11_01, 8'b01_10_11_01,
                                             8'b01_10_11_01, 8'b01_10_11_01,
                                             8'b01_01_01_01};
    localparam logic [7:0]  BPACK [NDUT] = '{8'd3, 8'd3, 8'd3, 8'hFC, 8'd7};

    // The same configuration in plain integers, for the model
    localparam int WTS    [NDUT][4] = '{'{1, -1, -2, 1}, '{1, -1, -2, 1},
                                        '{1, -1, -2, 1}, '{1, -1, -2, 1},
                                        '{1,  1,  1, 1}};
    localparam int BIAS_I [NDUT]    = '{3, 3, 3, -4, 7};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic [3:0] data_i = 4'b0000;

    logic        ready_o [NDUT];
    logic        valid_o [NDUT];
    logic [31:0] data_o  [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        logic signed [WOUT[k]-1:0] dout;

        neuron_seq #(
            .WidthIn     (1),
            .WidthOut    (WOUT[k]),
            .WeightWidth (2),
            .BiasWidth   (8),
            .InChannels  (4),
            .Lanes       (LANES[k]),
            .Weights     (WPACK[k]),
            .Bias        (BPACK[k])
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (valid_i),
            .ready_o (ready_o[k]),
            .data_i  (data_i),
            .valid_o (valid_o[k]),
            .ready_i (ready_i),
            .data_o  (dout)
        );

        assign data_o[k] = 32'(dout);
    end

    // ------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic int groups_of(int k);
        return 4 / LANES[k];
    endfunction

    // Bias plus the weights of the active channels, wrapped to WidthOut bits
    // and sign-extended to 32, with the optional clamp.
    function automatic logic [31:0] model_result(int k, logic [3:0] x);
        int          s;
        logic [31:0] r;
        logic [31:0] mask;
        s = BIAS_I[k];
        for (int ch = 0; ch < 4; ch++)
            if (x[ch]) s += WTS[k][ch];
        r = 32'(s);
        if (WOUT[k] < 32) begin
            mask = (32'd1 << WOUT[k]) - 32'd1;
            r    = r & mask;
            if (r[WOUT[k]-1]) r = r | ~mask;
        end
`ifdef NEURON_SEQ_RELU_EN
        if (r[31]) r = '0;
`endif
        return r;
    endfunction

    logic        m_busy  [NDUT] = '{default: 1'b0};
    int          m_cnt   [NDUT] = '{default: 0};
    logic        m_valid [NDUT] = '{default: 1'b0};
    logic [31:0] m_res   [NDUT] = '{default: 32'd0};
    logic [31:0] m_dout  [NDUT] = '{default: 32'd0};

    // Transaction-level model. An accepted vector produces its result N edges
    // later, and the result is held until an edge sees ready_i.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                m_busy[k] = 1'b0; m_cnt[k] = 0; m_valid[k] = 1'b0;
                m_res[k] = '0;    m_dout[k] = '0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (m_valid[k]) begin
                    if (ready_i) begin
                        m_valid[k] = 1'b0;
                        m_busy[k]  = 1'b0;
                    end
                end else if (m_busy[k]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_valid[k] = 1'b1;
                        m_dout[k]  = m_res[k];
                    end
                end else if (valid_i) begin
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = groups_of(k);
                    m_res[k]  = model_result(k, data_i);
                end
            end
        end
    end

    // Compare process: every output of every instance on every falling edge
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("cmp ready_o[%0d]", k), 32'(ready_o[k]), 32'(!m_busy[k]));
            check($sformatf("cmp valid_o[%0d]", k), 32'(valid_o[k]), 32'(m_valid[k]));
            check($sformatf("cmp data_o[%0d]",  k), data_o[k], m_dout[k]);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers
    // ------------------------------------------------------------------
    int          lat [NDUT];
    logic [31:0] res [NDUT];
    logic        rdy0_after;

    // Present x for exactly one edge. Return just after that handshake edge.
    task automatic handshake(input logic [3:0] x);
        @(posedge clk); #2;
        valid_i = 1'b1;
        data_i  = x;
        @(posedge clk); #2;
        valid_i = 1'b0;
        data_i  = ~x;   // the captured vector must not depend on data_i being held
    endtask

    // Record the edges from the handshake to valid_o and the value presented then.
    task automatic collect();
        for (int k = 0; k < NDUT; k++) begin lat[k] = 0; res[k] = 'x; end
        rdy0_after = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NDUT; k++)
                if (lat[k] == 0 && valid_o[k]) begin lat[k] = i; res[k] = data_o[k]; end
            if (lat[0] != 0 && i == lat[0] + 1) rdy0_after = ready_o[0];
        end
    endtask

    task automatic check_latencies(input string tag);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s latency[%0d]", tag, k), 32'(lat[k]), 32'(groups_of(k)));
    endtask

    // Wait until every instance is idle, with a bounded cycle budget.
    task automatic wait_idle(input string tag);
        logic all_idle;
        all_idle = 1'b0;
        for (int i = 0; i < 100 && !all_idle; i++) begin
            @(posedge clk); #2;
            all_idle = 1'b1;
            for (int k = 0; k < NDUT; k++) if (m_busy[k]) all_idle = 1'b0;
        end
        check({tag, " idle reached"}, 32'(all_idle), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] exp_neg;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset ready_o[%0d]", k), 32'(ready_o[k]), 32'd1);
            check($sformatf("reset valid_o[%0d]", k), 32'(valid_o[k]), 32'd0);
            check($sformatf("reset data_o[%0d]",  k), data_o[k], 32'd0);
        end

        // 1111: 3+1-1-2+1 = 2, and the 4-bit wrap 7+4 = 11 -> -5
        handshake(4'b1111);
        collect();
        check_latencies("t1111");
        check("t1111 data_o[0]", res[0], 32'd2);
        check("t1111 data_o[1]", res[1], 32'd2);
        check("t1111 data_o[2]", res[2], 32'd2);
`ifdef NEURON_SEQ_RELU_EN
        check("wrap data_o[4]", res[4], 32'd0);
`else
        check("wrap data_o[4]", res[4], -32'sd5);
`endif
        check("t1111 ready_o[0] next cycle", 32'(rdy0_after), 32'd1);
        wait_idle("t1111");

        // 0100: only ch2 (-2), 3-2 = 1 for every Lanes setting
        handshake(4'b0100);
        collect();
        check_latencies("t0100");
        check("t0100 data_o[0]", res[0], 32'd1);
        check("t0100 data_o[1]", res[1], 32'd1);
        check("t0100 data_o[2]", res[2], 32'd1);
        wait_idle("t0100");

        // Negative results with Bias = -4
`ifdef NEURON_SEQ_RELU_EN
        exp_neg = 32'd0;
`else
        exp_neg = -32'sd4;
`endif
        handshake(4'b0000);
        collect();
        check("neg 0000 data_o[3]", res[3], exp_neg);
        wait_idle("neg0000");
`ifdef NEURON_SEQ_RELU_EN
        exp_neg = 32'd0;
`else
        exp_neg = -32'sd2;
`endif
        handshake(4'b1001);
        collect();
        check("neg 1001 data_o[3]", res[3], exp_neg);
        check("pos 1001 data_o[0]", res[0], 32'd5);
        wait_idle("neg1001");

        // Backpressure: the result is held and a valid_i pulse is ignored
        ready_i = 1'b0;
        handshake(4'b1111);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i >= 4) begin
                check("bp valid_o[0]", 32'(valid_o[0]), 32'd1);
                check("bp data_o[0]",  data_o[0], 32'd2);
                check("bp ready_o[0]", 32'(ready_o[0]), 32'd0);
            end
            if (i == 6) begin #1 valid_i = 1'b1; data_i = 4'b0000; end
            if (i == 7) begin #1 valid_i = 1'b0; end
        end
        ready_i = 1'b1;
        wait_idle("backpressure");
        check("bp data_o[0] after release", data_o[0], 32'd2);

        // Reset during ACCUM at g=1: outputs clear at once, the transaction is dropped
        handshake(4'b1111);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("midreset valid_o[%0d]", k), 32'(valid_o[k]), 32'd0);
            check($sformatf("midreset data_o[%0d]",  k), data_o[k], 32'd0);
        end
        #10 rst_n = 1'b1;
        handshake(4'b1111);
        collect();
        check_latencies("after reset");
        check("after reset data_o[0]", res[0], 32'd2);
        wait_idle("after reset");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_neuron_seq
